// File: rtl/pwm_pkg.sv
// Shared definitions for the transducer PWM path: phase width, phase type,
// the layout of the 32-bit phase command word, and the duty-window compare.
package pwm_pkg;

   localparam int PHASE_W     = 8;
   localparam int PHASE_STEPS = 256;

   typedef logic [PHASE_W-1:0] phase_t;

   // 32-bit phase command word as written by the upstream register stage.
   localparam int CMD_W         = 32;
   localparam int CMD_PHASE_LSB = 0;
   localparam int CMD_PHASE_MSB = 7;
   localparam int CMD_CHAN_LSB  = 8;
   localparam int CMD_CHAN_MSB  = 15;
   localparam int CMD_EN_BIT    = 16;

   // True while the current step lies inside the high window that starts at
   // phase ph. The difference wraps at 8 bits. The compare is 9 bits wide,
   // so duty=256 covers every step.
   function automatic logic in_window(input phase_t step, input phase_t ph,
                                      input logic [PHASE_W:0] duty);
      phase_t rel;
      rel = step - ph;
      return ({1'b0, rel} < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Period timebase: a clock divider feeding a 256-step counter. It flags the
// last clock of each period (boundary) and pulses period_start in the first
// clock of the next period. A sync pulse restarts the period immediately.
// It is kept separate so that one instance can later drive a whole array,
// with step_cnt and boundary broadcast to every channel.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 5
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   sync,
   output phase_t step_cnt,
   output logic   boundary,
   output logic   period_start
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt;
   logic       div_last;

   assign div_last = (div_cnt == DIV_LAST);
   assign boundary = div_last && (step_cnt == phase_t'(PHASE_STEPS - 1));

   // Counter advance. Sync and boundary both restart the period, and a
   // coincident pair acts as a single restart.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt      <= '0;
         step_cnt     <= '0;
         period_start <= 1'b0;
      end else if (sync || boundary) begin
         div_cnt      <= '0;
         step_cnt     <= '0;
         period_start <= 1'b1;
      end else begin
         period_start <= 1'b0;
         if (div_last) begin
            div_cnt  <= '0;
            step_cnt <= step_cnt + phase_t'(1);
         end else begin
            div_cnt  <= div_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/pwm_channel.sv
// One transducer PWM channel. Phase and enable are captured into shadow
// registers only at a period restart (boundary or sync), so the output never
// carries a truncated pulse. The registered output lags the counter by one clk.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 5,
   parameter int DUTY    = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHASE_W-1:0] phase,
   input  logic               pwm_en,
   input  logic               sync,
   output logic               pwm_out,
   output logic               period_start,
   output logic               active
);

   localparam logic [PHASE_W:0] DUTY_STEPS = (PHASE_W + 1)'(DUTY);

   phase_t step_cnt;
   logic   boundary;
   phase_t phase_sh;
   logic   en_sh;

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk          (clk),
      .rst          (rst),
      .sync         (sync),
      .step_cnt     (step_cnt),
      .boundary     (boundary),
      .period_start (period_start)
   );

   // Shadow load. Only the request present in the restart cycle takes effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_sh <= '0;
         en_sh    <= 1'b0;
      end else if (sync || boundary) begin
         phase_sh <= phase;
         en_sh    <= pwm_en;
      end
   end

   // Registered output: high while the step is inside the shifted duty window.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= en_sh && in_window(step_cnt, phase_sh, DUTY_STEPS);
      end
   end

   assign active = en_sh;

endmodule

// File: tb/tb_pwm_channel.sv
// Directed bench for pwm_channel with CLK_DIV=2 (512-clock period). Three
// instances share every input and use DUTY=128, 0 and 256.
module tb_pwm_channel;

   localparam int CLK_DIV = 2;
   localparam int PERIOD  = 256 * CLK_DIV;
   localparam int LIMIT   = 600;

   // ---------------- clock / reset / stimulus signals ----------------
   logic       clk;
   logic       rst;
   logic [7:0] phase;
   logic       pwm_en;
   logic       sync;

   logic pwm_out_m, ps_m, active_m;
   logic out_d0, ps_d0, act_d0;
   logic out_d256, ps_d256, act_d256;

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pwm_channel #(.CLK_DIV(CLK_DIV), .DUTY(128)) dut (
      .clk(clk), .rst(rst), .phase(phase), .pwm_en(pwm_en), .sync(sync),
      .pwm_out(pwm_out_m), .period_start(ps_m), .active(active_m)
   );

   pwm_channel #(.CLK_DIV(CLK_DIV), .DUTY(0)) dut_d0 (
      .clk(clk), .rst(rst), .phase(phase), .pwm_en(pwm_en), .sync(sync),
      .pwm_out(out_d0), .period_start(ps_d0), .active(act_d0)
   );

   pwm_channel #(.CLK_DIV(CLK_DIV), .DUTY(256)) dut_d256 (
      .clk(clk), .rst(rst), .phase(phase), .pwm_en(pwm_en), .sync(sync),
      .pwm_out(out_d256), .period_start(ps_d256), .active(act_d256)
   );

   // ---------------- driver / checker tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Tick until period_start (bounded); count clocks and any high output.
   task automatic wait_ps(output int n, output int highs);
      n = 0;
      highs = 0;
      while (n < LIMIT) begin
         tick();
         n++;
         if (pwm_out_m === 1'b1 || out_d256 === 1'b1 || out_d0 === 1'b1) highs++;
         if (ps_m === 1'b1) break;
      end
   endtask

   // Entered in a period_start cycle. Walks one full period and checks it
   // against hand values plus the reference window model. At tick chg_k it
   // drives phase/pwm_en, and at tick sync_k it raises sync for one clock.
   task automatic check_period(input string tag, input int exp_phase,
                               input int exp_en, input int exp_highs,
                               input int exp_rise, input int exp_rises,
                               input int chg_k, input int chg_phase,
                               input int chg_en, input int sync_k);
      int   highs = 0;
      int   rises = 0;
      int   first_rise = -1;
      int   model_miss = 0;
      int   ps_bad = 0;
      int   d0_highs = 0;
      int   d256_highs = 0;
      int   step;
      int   rel;
      logic exp_out;
      logic prev;
      prev = pwm_out_m;
      for (int k = 1; k <= PERIOD; k++) begin
         tick();
         sync = 1'b0;
         if (k == 1) check({tag, "_active"}, int'(active_m), exp_en);
         step    = (k - 1) / CLK_DIV;
         rel     = (step - exp_phase + 256) % 256;
         exp_out = (exp_en != 0) && (rel < 128);
         if (pwm_out_m !== exp_out) model_miss++;
         if (pwm_out_m === 1'b1) highs++;
         if (pwm_out_m === 1'b1 && prev === 1'b0) begin
            rises++;
            if (first_rise < 0) first_rise = k;
         end
         prev = pwm_out_m;
         if (out_d0 === 1'b1) d0_highs++;
         if (out_d256 === 1'b1) d256_highs++;
         if (k < PERIOD && ps_m !== 1'b0) ps_bad++;
         if (ps_d0 !== ps_m || ps_d256 !== ps_m || act_d0 !== active_m || act_d256 !== active_m)
            ps_bad++;
         if (k == chg_k) begin
            phase  = 8'(chg_phase);
            pwm_en = chg_en[0];
         end
         if (k == sync_k) sync = 1'b1;
      end
      check({tag, "_highs"}, highs, exp_highs);
      check({tag, "_first_rise"}, first_rise, exp_rise);
      check({tag, "_rises"}, rises, exp_rises);
      check({tag, "_model_miss"}, model_miss, 0);
      check({tag, "_ps_bad"}, ps_bad, 0);
      check({tag, "_ps_end"}, int'(ps_m), 1);
      check({tag, "_d0_highs"}, d0_highs, 0);
      check({tag, "_d256_highs"}, d256_highs, (exp_en != 0) ? PERIOD : 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int highs;

      rst    = 1'b1;
      phase  = 8'd0;
      pwm_en = 1'b1;
      sync   = 1'b0;
      repeat (3) tick();
      check("reset_out", int'(pwm_out_m), 0);
      check("reset_ps", int'(ps_m), 0);
      check("reset_active", int'(active_m), 0);
      check("reset_d256_out", int'(out_d256), 0);

      // First period after reset: nothing loaded yet, so the output stays low.
      rst = 1'b0;
      wait_ps(n, highs);
      check("startup_len", n, PERIOD);
      check("startup_highs", highs, 0);

      // Phase sweep; each new phase is requested one period ahead.
      phase = 8'd64;
      check_period("p0", 0, 1, 256, 1, 1, -1, 0, 0, -1);
      phase = 8'd200;
      check_period("p64", 64, 1, 256, 129, 1, -1, 0, 0, -1);
      phase = 8'd10;
      check_period("p200", 200, 1, 256, 1, 2, -1, 0, 0, -1);
      // Phase changed to 100 at step 50: current period keeps 10.
      check_period("p10", 10, 1, 256, 21, 1, 100, 100, 1, -1);
      check_period("p100", 100, 1, 256, 201, 1, -1, 0, 0, -1);

      // Sync at step 37 restarts the period and loads phase 150.
      for (int k = 1; k <= 74; k++) tick();
      check("sync_pre_ps", int'(ps_m), 0);
      phase = 8'd150;
      sync  = 1'b1;
      tick();
      sync = 1'b0;
      check("sync_ps", int'(ps_m), 1);

      // Sync coincident with the boundary cycle: a single restart, phase 30.
      check_period("p150", 150, 1, 256, 1, 2, 511, 30, 1, 511);

      // Back-to-back sync pulses: period_start held every cycle.
      sync = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("b2b_ps", int'(ps_m), 1);
      end
      sync = 1'b0;

      // Disable mid-period: this period runs normally, the next one is dark.
      check_period("p30", 30, 1, 256, 61, 1, 200, 30, 0, -1);
      check_period("off", 30, 0, 0, -1, 0, 300, 30, 1, -1);

      // Reset asserted while the output is high.
      for (int k = 1; k <= 70; k++) tick();
      check("pre_rst_out", int'(pwm_out_m), 1);
      check("pre_rst_active", int'(active_m), 1);
      rst = 1'b1;
      tick();
      check("mid_rst_out", int'(pwm_out_m), 0);
      check("mid_rst_active", int'(active_m), 0);
      check("mid_rst_ps", int'(ps_m), 0);
      check("mid_rst_d256_out", int'(out_d256), 0);
      rst = 1'b0;
      wait_ps(n, highs);
      check("post_rst_len", n, PERIOD);
      check("post_rst_highs", highs, 0);
      tick();
      check("post_rst_d256_on", int'(out_d256), 1);
      check("post_rst_out", int'(pwm_out_m), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
